// File: rtl/temporizador_multicanal.sv
// -----------------------------------------------------------------------------
// temporizador_multicanal
//
// N-channel dosing timer. After a start request, each channel output stays
// high for level*CYC_PER_STEP clock cycles. A shared prescaler generates
// level steps, and a step counter compares against each channel's captured
// level. The datapath has no multipliers or dividers.
//
// In one-shot mode the run ends once the largest level has elapsed, and done
// pulses for one cycle. In continuous mode the period is always LVL_MAX steps.
// The levels are recaptured at every period boundary.
//
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   start   start request, only honoured while idle
//   abort   return to idle at the next edge (wins over start)
//   mode    0 = one-shot, 1 = continuous, captured together with start
//   levels  packed per-channel levels, channel i = levels[i*LVL_W +: LVL_W]
//   out     per-channel drive, 1 = pump/motor on
//   busy    high while running
//   done    one-cycle pulse when a one-shot run completes
//   err     sticky flag: the last capture contained a level above LVL_MAX
// -----------------------------------------------------------------------------
module temporizador_multicanal #(
    parameter int N_CH         = 3,
    parameter int LVL_W        = 5,
    parameter int LVL_MAX      = 15,
    parameter int CYC_PER_STEP = 33_333
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    mode,
    input  logic [N_CH*LVL_W-1:0]   levels,
    output logic [N_CH-1:0]         out,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int PS_W   = $clog2(CYC_PER_STEP);
    localparam int STEP_W = $clog2(LVL_MAX + 1);

    localparam logic [PS_W-1:0]   PS_LAST   = PS_W'(CYC_PER_STEP - 1);
    localparam logic [STEP_W-1:0] STEP_FULL = STEP_W'(LVL_MAX);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                          state_q, state_d;
    logic [PS_W-1:0]                 presc_q, presc_d;
    logic [STEP_W-1:0]               step_q, step_d;
    logic [N_CH-1:0][STEP_W-1:0]     lvl_q, lvl_d;
    logic [STEP_W-1:0]               max_q, max_d;
    logic                            mode_q, mode_d;
    logic                            done_q, done_d;
    logic                            err_q, err_d;

    logic [N_CH-1:0][STEP_W-1:0]     snap_lvl;
    logic [STEP_W-1:0]               snap_max;
    logic                            snap_err;
    logic [LVL_W-1:0]                lvl_in;
    logic [STEP_W-1:0]               step_inc;
    logic                            presc_wrap;

    // Clamped copy of the level inputs, with its maximum and the
    // out-of-range flag. These values are ready whenever a capture happens.
    always_comb begin
        snap_lvl = '0;
        snap_max = '0;
        snap_err = 1'b0;
        lvl_in   = '0;
        for (int i = 0; i < N_CH; i++) begin
            lvl_in = levels[i*LVL_W +: LVL_W];
            if (32'(lvl_in) > 32'(LVL_MAX)) begin
                snap_lvl[i] = STEP_FULL;
                snap_err    = 1'b1;
            end else begin
                snap_lvl[i] = STEP_W'(lvl_in);
            end
            if (snap_lvl[i] > snap_max) begin
                snap_max = snap_lvl[i];
            end
        end
    end

    assign step_inc   = step_q + STEP_W'(1);
    assign presc_wrap = (presc_q == PS_LAST);

    // Next-state logic for the IDLE/RUN controller and its counters.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        step_d  = step_q;
        lvl_d   = lvl_q;
        max_d   = max_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        err_d   = err_q;

        if (abort) begin
            state_d = IDLE;
            presc_d = '0;
            step_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        lvl_d   = snap_lvl;
                        max_d   = snap_max;
                        err_d   = snap_err;
                        mode_d  = mode;
                        presc_d = '0;
                        step_d  = '0;
                        // An all-zero capture has nothing to dose, so it
                        // completes immediately.
                        if (snap_max == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (presc_wrap) begin
                        presc_d = '0;
                        if (!mode_q && (step_inc == max_q)) begin
                            state_d = IDLE;
                            step_d  = '0;
                            done_d  = 1'b1;
                        end else if (mode_q && (step_inc == STEP_FULL)) begin
                            // Period boundary. New levels take effect here.
                            step_d = '0;
                            lvl_d  = snap_lvl;
                            max_d  = snap_max;
                            err_d  = snap_err;
                        end else begin
                            step_d = step_inc;
                        end
                    end else begin
                        presc_d = presc_q + PS_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            presc_q <= '0;
            step_q  <= '0;
            lvl_q   <= '0;
            max_q   <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            step_q  <= step_d;
            lvl_q   <= lvl_d;
            max_q   <= max_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Outputs are decoded from registered state only. Reset therefore clears
    // out and busy at once, without waiting for a clock edge.
    always_comb begin
        out = '0;
        for (int i = 0; i < N_CH; i++) begin
            out[i] = (state_q == RUN) && (step_q < lvl_q[i]);
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_temporizador_multicanal.sv
// -----------------------------------------------------------------------------
// tb_temporizador_multicanal
//
// Self-checking bench for temporizador_multicanal (N_CH=3, LVL_W=5,
// LVL_MAX=15, CYC_PER_STEP=4). The reference model tracks elapsed cycles
// since the start of each run or period. A channel is on while the elapsed
// time is below level*CYC_PER_STEP.
// -----------------------------------------------------------------------------
module tb_temporizador_multicanal;

    localparam int N_CH    = 3;
    localparam int LVL_W   = 5;
    localparam int LVL_MAX = 15;
    localparam int CYC     = 4;

    logic                   clk    = 1'b0;
    logic                   rst_n  = 1'b0;
    logic                   start  = 1'b0;
    logic                   abort  = 1'b0;
    logic                   mode   = 1'b0;
    logic [N_CH*LVL_W-1:0]  levels = '0;
    logic [N_CH-1:0]        out;
    logic                   busy;
    logic                   done;
    logic                   err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_running;
    bit m_mode;
    bit m_done;
    bit m_err;
    int m_t;
    int m_max;
    int m_lvl[N_CH];

    logic [N_CH+2:0] got;
    logic [N_CH+2:0] exp_v;

    temporizador_multicanal #(
        .N_CH         (N_CH),
        .LVL_W        (LVL_W),
        .LVL_MAX      (LVL_MAX),
        .CYC_PER_STEP (CYC)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .abort  (abort),
        .mode   (mode),
        .levels (levels),
        .out    (out),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_running = 1'b0;
        m_mode    = 1'b0;
        m_done    = 1'b0;
        m_err     = 1'b0;
        m_t       = 0;
        m_max     = 0;
        for (int i = 0; i < N_CH; i++) m_lvl[i] = 0;
    endfunction

    function automatic void model_snapshot();
        m_max = 0;
        m_err = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            int v;
            v = int'(levels[i*LVL_W +: LVL_W]);
            if (v > LVL_MAX) begin
                v     = LVL_MAX;
                m_err = 1'b1;
            end
            m_lvl[i] = v;
            if (v > m_max) m_max = v;
        end
    endfunction

    // Predicts the effect of the coming clock edge from the current inputs.
    function automatic void model_edge();
        if (!rst_n) begin
            model_reset();
        end else if (abort) begin
            m_running = 1'b0;
            m_done    = 1'b0;
            m_t       = 0;
        end else if (!m_running) begin
            m_done = 1'b0;
            if (start) begin
                model_snapshot();
                m_mode = mode;
                m_t    = 0;
                if (m_max == 0) m_done = 1'b1;
                else            m_running = 1'b1;
            end
        end else begin
            m_done = 1'b0;
            m_t++;
            if (!m_mode && m_t == m_max * CYC) begin
                m_running = 1'b0;
                m_done    = 1'b1;
            end else if (m_mode && m_t == LVL_MAX * CYC) begin
                m_t = 0;
                model_snapshot();
            end
        end
    endfunction

    function automatic logic [N_CH-1:0] model_out();
        logic [N_CH-1:0] o;
        o = '0;
        for (int i = 0; i < N_CH; i++) o[i] = m_running && (m_t < m_lvl[i] * CYC);
        return o;
    endfunction

    function automatic logic [N_CH+2:0] model_expected();
        return {model_out(), m_running, m_done, m_err};
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 6; c++) begin
            start  = 1'($urandom);
            abort  = 1'($urandom);
            mode   = 1'($urandom);
            levels = 15'($urandom);
            tick();
            got = {out, busy, done, err};
            checks++;
            if (got !== '0) begin
                errors++;
                $display("[TB] FAIL reset_hold cycle %0d: got %b, expected 000000", c, got);
            end
        end
        start = 1'b0;
        abort = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            levels = 15'($urandom);
            mode   = 1'($urandom);
            tick();
            got = {out, busy, done, err};
            checks++;
            if (got !== '0) begin
                errors++;
                $display("[TB] FAIL reset_idle cycle %0d: got %b, expected 000000", c, got);
            end
        end
    endtask

    task automatic test_oneshot();
        int cnt0, cnt1, cnt2, cnt_busy, cnt_done, last_busy, done_at;
        cnt0 = 0; cnt1 = 0; cnt2 = 0; cnt_busy = 0; cnt_done = 0;
        last_busy = -1; done_at = -1;
        mode   = 1'b0;
        levels = {5'd15, 5'd0, 5'd3};
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int c = 0; c < 70; c++) begin
            got   = {out, busy, done, err};
            exp_v = model_expected();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("[TB] FAIL oneshot cycle %0d: got %b, expected %b", c, got, exp_v);
            end
            cnt0 += int'(out[0]);
            cnt1 += int'(out[1]);
            cnt2 += int'(out[2]);
            if (busy) begin
                cnt_busy++;
                last_busy = c;
            end
            if (done) begin
                cnt_done++;
                done_at = c;
            end
            tick();
        end
        checks++;
        if (cnt0 != 12) begin
            errors++;
            $display("[TB] FAIL oneshot_out0_len: got %0d, expected 12", cnt0);
        end
        checks++;
        if (cnt1 != 0) begin
            errors++;
            $display("[TB] FAIL oneshot_out1_len: got %0d, expected 0", cnt1);
        end
        checks++;
        if (cnt2 != 60) begin
            errors++;
            $display("[TB] FAIL oneshot_out2_len: got %0d, expected 60", cnt2);
        end
        checks++;
        if (cnt_busy != 60) begin
            errors++;
            $display("[TB] FAIL oneshot_busy_len: got %0d, expected 60", cnt_busy);
        end
        checks++;
        if (cnt_done != 1 || done_at != last_busy + 1) begin
            errors++;
            $display("[TB] FAIL oneshot_done: got %0d pulses at %0d, expected 1 at %0d",
                     cnt_done, done_at, last_busy + 1);
        end
    endtask

    task automatic test_zero();
        levels = '0;
        mode   = 1'b0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        got    = {out, busy, done};
        checks++;
        if (got[N_CH+1:0] !== 5'b00001) begin
            errors++;
            $display("[TB] FAIL zero_done: got %b, expected 00001", got[N_CH+1:0]);
        end
        tick();
        got   = {out, busy, done, err};
        exp_v = model_expected();
        checks++;
        if (got !== exp_v || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_after: got %b, expected %b", got, exp_v);
        end
    endtask

    task automatic test_clamp();
        int cnt1;
        cnt1   = 0;
        mode   = 1'b0;
        levels = {5'($urandom_range(0, 15)), 5'd20, 5'($urandom_range(0, 15))};
        start  = 1'b1;
        tick();
        start  = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clamp_err_set: got %b, expected 1", err);
        end
        for (int c = 0; c < 65; c++) begin
            got   = {out, busy, done, err};
            exp_v = model_expected();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("[TB] FAIL clamp cycle %0d: got %b, expected %b", c, got, exp_v);
            end
            cnt1 += int'(out[1]);
            tick();
        end
        checks++;
        if (cnt1 != 60) begin
            errors++;
            $display("[TB] FAIL clamp_out1_len: got %0d, expected 60", cnt1);
        end
        levels = {5'($urandom_range(1, 15)), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
        start  = 1'b1;
        tick();
        start  = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clamp_err_clear: got %b, expected 0", err);
        end
        repeat (62) tick();
    endtask

    task automatic test_abort();
        mode   = 1'b0;
        levels = {5'd15, 5'd0, 5'd3};
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            got   = {out, busy, done, err};
            exp_v = model_expected();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("[TB] FAIL abort_pre cycle %0d: got %b, expected %b", c, got, exp_v);
            end
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        got   = {out, busy, done};
        checks++;
        if (got[N_CH+1:0] !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL abort_stop: got %b, expected 00000", got[N_CH+1:0]);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            got   = {out, busy, done, err};
            exp_v = model_expected();
            checks++;
            if (got !== exp_v || done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL abort_post cycle %0d: got %b, expected %b", c, got, exp_v);
            end
        end
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== '0) begin
            errors++;
            $display("[TB] FAIL abort_with_start: got busy=%b done=%b out=%b, expected 0 0 000",
                     busy, done, out);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_with_start_late: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_continuous();
        int per_cnt[4];
        for (int p = 0; p < 4; p++) per_cnt[p] = 0;
        mode   = 1'b1;
        levels = {5'd0, 5'd0, 5'd5};
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int c = 0; c < 240; c++) begin
            got   = {out, busy, done, err};
            exp_v = model_expected();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("[TB] FAIL continuous cycle %0d: got %b, expected %b", c, got, exp_v);
            end
            per_cnt[c / 60] += int'(out[0]);
            if (c == 90) levels = {5'd0, 5'd0, 5'd10};
            start = ($urandom_range(0, 5) == 0);
            mode  = 1'($urandom);
            tick();
        end
        start = 1'b0;
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (per_cnt[p] != ((p < 2) ? 20 : 40)) begin
                errors++;
                $display("[TB] FAIL continuous_duty period %0d: got %0d, expected %0d",
                         p, per_cnt[p], (p < 2) ? 20 : 40);
            end
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: got out=%b busy=%b done=%b, expected 000 0 0",
                     out, busy, done);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_no_restart: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 39) == 0);
            mode  = 1'($urandom);
            rst_n = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < N_CH; i++) levels[i*LVL_W +: LVL_W] = 5'($urandom_range(0, 20));
            end
            tick();
            got   = {out, busy, done, err};
            exp_v = model_expected();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("[TB] FAIL random cycle %0d: got %b, expected %b", c, got, exp_v);
            end
        end
        start = 1'b0;
        abort = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_oneshot();
        test_zero();
        test_clamp();
        test_abort();
        test_continuous();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
